// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses on a word-addressed memory.
// Sub-word stores do a read-modify-write; misaligned or illegal sizes end in an error response.
module load_store_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespErr,
    output logic [31:0] Address,
    output logic [31:0] writeData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic               r_signed;
    logic               r_err;
    logic [1:0]         r_size;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_resp_data;

    logic               w_accept;
    logic               w_req_err;
    logic               w_rd_last;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_ext;
    logic [31:0]        w_merged;

    assign w_accept  = ReqValid && (r_state == IDLE);
    assign w_req_err = (ReqSize == 2'b11)
                    || ((ReqSize == 2'b01) && ReqAddr[0])
                    || ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));
    assign w_rd_last = (r_state == RD) && (r_cnt == CNT_W'(MEM_LAT - 1));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err)
                        w_state_next = RESP;
                    else if (ReqWrite && (ReqSize == 2'b10))
                        w_state_next = WR;
                    else
                        w_state_next = RD;
                end
            end
            RD:      if (w_rd_last) w_state_next = r_write ? WR : RESP;
            WR:      w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Little-endian lane extraction from the word being returned this cycle.
    assign w_byte = ReadData[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = ReadData[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = ReadData;
        if (r_size == 2'b00)
            w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
        else if (r_size == 2'b01)
            w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
    end

    // Read-modify-write merge: only the addressed lane takes the store data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] =
                ((r_size == 2'b00) && (r_addr[1:0] == 2'(gi))) ? r_wdata[7:0] :
                ((r_size == 2'b01) && (r_addr[1] == 1'(gi / 2))) ? r_wdata[8*(gi % 2) +: 8] :
                ReadData[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_wdata <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_write     <= ReqWrite;
                r_signed    <= ReqSigned;
                r_err       <= w_req_err;
                r_size      <= ReqSize;
                r_addr      <= ReqAddr;
                r_wdata     <= ReqWData;
                r_cnt       <= '0;
                r_resp_data <= '0;
                if (ReqWrite && (ReqSize == 2'b10) && !w_req_err)
                    r_mem_wdata <= ReqWData;
            end
            if (r_state == RD) begin
                if (w_rd_last) begin
                    r_cnt <= '0;
                    if (r_write)
                        r_mem_wdata <= w_merged;
                    else
                        r_resp_data <= w_load_ext;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign ReqReady  = (r_state == IDLE);
    assign MemRead   = (r_state == RD);
    assign MemWrite  = (r_state == WR);
    assign RespValid = (r_state == RESP);
    assign RespData  = (r_state == RESP) ? r_resp_data : 32'h0;
    assign RespErr   = (r_state == RESP) && r_err;
    assign Address   = {r_addr[31:2], 2'b00};
    assign writeData = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT 1 and 3) share request inputs and are
// checked against a word-array memory model with latencies taken from the timing rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] resp_data  [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];

    logic [31:0] mem     [2][16];
    logic [31:0] ref_mem [16];

    int n_cmp = 0;
    int n_err = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            assign read_data[gi] = mem[gi][address[gi][5:2]];
            load_store_unit #(.MEM_LAT(gi == 0 ? 1 : 3)) u_dut (
                .Clk       (clk),
                .Rst_n     (rst_n),
                .ReqValid  (req_valid[gi]),
                .ReqReady  (req_ready[gi]),
                .ReqWrite  (req_write),
                .ReqSize   (req_size),
                .ReqSigned (req_signed),
                .ReqAddr   (req_addr),
                .ReqWData  (req_wdata),
                .RespValid (resp_valid[gi]),
                .RespData  (resp_data[gi]),
                .RespErr   (resp_err[gi]),
                .Address   (address[gi]),
                .writeData (write_data[gi]),
                .MemRead   (mem_read[gi]),
                .MemWrite  (mem_write[gi]),
                .ReadData  (read_data[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic wait_ready(input logic [1:0] need);
        int guard = 0;
        while (((req_ready & need) !== need) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", req_ready & need, need);
    endtask

    task automatic garble_req();
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    // One request to both instances; returns instance 0's response data and store word.
    task automatic do_txn(input bit w, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] o_data0, output logic [31:0] o_wd0);
        bit          err;
        logic [31:0] word, lane, exp_data, mask, new_word;
        int          sh, exp_resp, exp_rd, exp_wr;
        int          resp_cyc[2], resp_cnt[2], rd_cnt[2], wr_cnt[2];
        logic [31:0] got_data[2], got_wd[2];
        logic        got_err[2];
        bit          addr_bad[2], overlap[2], stray[2];
        logic [1:0]  ready_c1;

        err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        word = ref_mem[a[5:2]];
        sh   = (sz == 2'd1) ? (a[1] ? 16 : 0) : ((sz == 2'd0) ? 8 * int'(a[1:0]) : 0);
        lane = word >> sh;
        if (sz == 2'd0) begin
            exp_data = lane & 32'hFF;
            if (sgn && lane[7]) exp_data = exp_data | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            exp_data = lane & 32'hFFFF;
            if (sgn && lane[15]) exp_data = exp_data | 32'hFFFF_0000;
        end else begin
            exp_data = word;
        end
        if (w || err) exp_data = 32'h0;
        mask     = (sz == 2'd0) ? (32'hFF << sh) : (sz == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        new_word = (word & ~mask) | ((wd << sh) & mask);
        if (w && !err) ref_mem[a[5:2]] = new_word;

        wait_ready(2'b11);
        req_write  = w;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        garble_req();

        for (int d = 0; d < 2; d++) begin
            resp_cyc[d] = 0; resp_cnt[d] = 0; rd_cnt[d] = 0; wr_cnt[d] = 0;
            got_data[d] = 32'h0; got_wd[d] = 32'h0; got_err[d] = 1'b0;
            addr_bad[d] = 1'b0; overlap[d] = 1'b0; stray[d] = 1'b0;
        end
        ready_c1 = 2'b00;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) ready_c1 = req_ready;
            for (int d = 0; d < 2; d++) begin
                if (mem_read[d] && mem_write[d]) overlap[d] = 1'b1;
                if ((mem_read[d] || mem_write[d]) && address[d] !== {a[31:2], 2'b00})
                    addr_bad[d] = 1'b1;
                if (mem_read[d]) rd_cnt[d]++;
                if (mem_write[d]) begin
                    wr_cnt[d]++;
                    got_wd[d] = write_data[d];
                    mem[d][address[d][5:2]] = write_data[d];
                end
                if (resp_valid[d]) begin
                    resp_cnt[d]++;
                    if (resp_cyc[d] == 0) resp_cyc[d] = c;
                    got_data[d] = resp_data[d];
                    got_err[d]  = resp_err[d];
                end else if (resp_data[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
                    stray[d] = 1'b1;
                end
            end
        end

        check("busy_not_ready", ready_c1, 2'b00);
        for (int d = 0; d < 2; d++) begin
            exp_resp = err ? 1 : (!w ? lat_of(d) + 1 : (sz == 2'd2 ? 2 : lat_of(d) + 2));
            exp_rd   = (!err && (!w || sz != 2'd2)) ? lat_of(d) : 0;
            exp_wr   = (!err && w) ? 1 : 0;
            check($sformatf("d%0d_resp_cycle", d), resp_cyc[d], exp_resp);
            check($sformatf("d%0d_resp_count", d), resp_cnt[d], 1);
            check($sformatf("d%0d_memread_cycles", d), rd_cnt[d], exp_rd);
            check($sformatf("d%0d_memwrite_cycles", d), wr_cnt[d], exp_wr);
            check($sformatf("d%0d_resp_data", d), got_data[d], exp_data);
            check($sformatf("d%0d_resp_err", d), got_err[d], err);
            if (exp_wr != 0) check($sformatf("d%0d_write_data", d), got_wd[d], new_word);
            check($sformatf("d%0d_address", d), addr_bad[d], 0);
            check($sformatf("d%0d_rd_wr_overlap", d), overlap[d], 0);
            check($sformatf("d%0d_idle_resp_fields", d), stray[d], 0);
        end
        o_data0 = got_data[0];
        o_wd0   = got_wd[0];
        $display("txn w=%0d size=%0d signed=%0d addr=%h wdata=%h -> data0=%h data1=%h err=%0d%0d",
                 w, sz, sgn, a, wd, got_data[0], got_data[1], got_err[0], got_err[1]);
    endtask

    // Half store interrupted by reset while both instances are in their read phase.
    task automatic do_reset_mid();
        logic [1:0] seen_wr, seen_resp;
        wait_ready(2'b11);
        req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000_1234;
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("rst_in_rd_phase", mem_read, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready_after", req_ready, 2'b11);
        check("rst_memread_after", mem_read, 2'b00);
        check("rst_address_after", address[0], 32'h0);
        seen_wr   = mem_write;
        seen_resp = resp_valid;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            seen_wr   = seen_wr | mem_write;
            seen_resp = seen_resp | resp_valid;
        end
        check("rst_no_memwrite", seen_wr, 2'b00);
        check("rst_no_respvalid", seen_resp, 2'b00);
        $display("txn reset during half store @00000012 -> aborted");
    endtask

    // Word load on the MEM_LAT=3 instance with ReqValid held through the response.
    task automatic do_hold();
        int          rd1, rd2, rc1, rc2;
        logic [31:0] d1, d2;
        rd1 = 0; rd2 = 0; rc1 = 0; rc2 = 0; d1 = 32'h0; d2 = 32'h0;
        wait_ready(2'b10);
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 2'b10;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (mem_read[1]) rd1++;
            if (resp_valid[1] && rc1 == 0) begin rc1 = c; d1 = resp_data[1]; end
            if (c == 5) check("hold_ready_n5", req_ready[1], 1'b1);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            if (c == 6) check("hold_reaccept_memread", mem_read[1], 1'b1);
            if (mem_read[1]) rd2++;
            if (resp_valid[1] && rc2 == 0) begin rc2 = c; d2 = resp_data[1]; end
        end
        check("hold_memread_cycles", rd1, 3);
        check("hold_resp_cycle", rc1, 4);
        check("hold_resp_data", d1, 32'h8899_AABB);
        check("hold2_memread_cycles", rd2, 3);
        check("hold2_resp_cycle", rc2, 9);
        check("hold2_resp_data", d2, 32'h8899_AABB);
        $display("txn held-valid word load @00000010 (MEM_LAT=3) -> %h then %h", d1, d2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, wd0;
        logic [1:0]  sz;
        logic [31:0] a;

        rst_n = 1'b0;
        req_valid = 2'b00;
        req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h8899_AABB;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = ref_mem[i];
            mem[1][i] = ref_mem[i];
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", req_ready, 2'b11);
        check("reset_memread", mem_read, 2'b00);
        check("reset_memwrite", mem_write, 2'b00);
        check("reset_respvalid", resp_valid, 2'b00);
        check("reset_resperr", resp_err, 2'b00);
        check("reset_respdata", resp_data[0] | resp_data[1], 32'h0);
        check("reset_address", address[0] | address[1], 32'h0);
        check("reset_writedata", write_data[0] | write_data[1], 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, d0, wd0);
        check("spec_signed_byte_load", d0, 32'hFFFF_FF88);
        do_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, d0, wd0);
        check("spec_unsigned_half_load", d0, 32'h0000_8899);
        do_hold();
        do_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_005A, d0, wd0);
        check("spec_byte_store_wdata", wd0, 32'h8899_5ABB);
        do_txn(1'b1, 2'd2, 1'b0, 32'h12, 32'hDEAD_BEEF, d0, wd0);
        check("spec_misaligned_word_data", d0, 32'h0);
        do_reset_mid();

        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, d0, wd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
